// File: rtl/seq_multiplier_radix_taint_pkg.sv
// Shared definitions for the taint-tracked radix sequential multiplier:
// FSM encodings, strobe bundle and counter sizing.
package seq_multiplier_radix_taint_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Strobes from the controller to the datapath; all carry the ctrl taint.
    typedef struct packed {
        logic load;
        logic step;
        logic finish;
    } strobe_t;

    function automatic int iter_of(input int width, input int radix_bits);
        return width / radix_bits;
    endfunction

    // Counter must hold ITER-1; a single-iteration build still gets one bit.
    function automatic int cnt_w(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_radix_taint_if.sv
// Request/response bundle of the multiplier; every signal has a taint twin.
interface seq_multiplier_radix_taint_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 start_t;
    logic                 signed_mode;
    logic                 signed_mode_t;
    logic [WIDTH-1:0]     multiplier;
    logic                 multiplier_t;
    logic [WIDTH-1:0]     multiplicand;
    logic                 multiplicand_t;
    logic [2*WIDTH-1:0]   product;
    logic                 product_t;
    logic                 busy;
    logic                 busy_t;
    logic                 productDone;
    logic                 productDone_t;

    modport slave (
        input  start, start_t, signed_mode, signed_mode_t,
        input  multiplier, multiplier_t, multiplicand, multiplicand_t,
        output product, product_t, busy, busy_t, productDone, productDone_t
    );

    modport master (
        output start, start_t, signed_mode, signed_mode_t,
        output multiplier, multiplier_t, multiplicand, multiplicand_t,
        input  product, product_t, busy, busy_t, productDone, productDone_t
    );
endinterface

// File: rtl/seq_multiplier_radix_taint_ctrl.sv
// Controller: IDLE/CALC/DONE sequencing, iteration counter and sticky control taint.
// Timing depends only on ITER, so operand data never influences control.
module seq_multiplier_radix_taint_ctrl
    import seq_multiplier_radix_taint_pkg::*;
#(
    parameter int ITER = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_start,
    input  logic    i_start_t,
    output strobe_t o_stb,
    output logic    o_ctrl_t,
    output logic    o_busy,
    output logic    o_done
);
    localparam int             CW   = cnt_w(ITER);
    localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ctrl_t;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_comb begin
        o_stb        = '0;
        o_stb.load   = (r_state == ST_IDLE) && i_start;
        o_stb.step   = (r_state == ST_CALC);
        o_stb.finish = (r_state == ST_CALC) && w_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ctrl_t <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A tainted start taints timing whether or not it is asserted.
                    r_ctrl_t <= r_ctrl_t | i_start_t;
                    if (i_start) begin
                        r_state <= ST_CALC;
                        r_cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ctrl_t = r_ctrl_t;
    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_DONE);

endmodule

// File: rtl/seq_multiplier_radix_taint.sv
// Constant-time WIDTH x WIDTH sequential multiplier retiring RADIX_BITS bits per
// cycle, with optional two's-complement mode and word-level taint on every output.
module seq_multiplier_radix_taint
    import seq_multiplier_radix_taint_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RADIX_BITS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    seq_multiplier_radix_taint_if.slave   io_bus
);
    localparam int ITER = iter_of(WIDTH, RADIX_BITS);
    localparam int PW   = 2 * WIDTH;

    if (WIDTH < 2 || (WIDTH % RADIX_BITS) != 0 ||
        !(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4)) begin : g_bad_param
        $error("seq_multiplier_radix_taint: unsupported WIDTH/RADIX_BITS");
    end

    strobe_t w_stb;
    logic    w_ctrl_t;
    logic    w_busy;
    logic    w_done;

    seq_multiplier_radix_taint_ctrl #(
        .ITER (ITER)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_start   (io_bus.start),
        .i_start_t (io_bus.start_t),
        .o_stb     (w_stb),
        .o_ctrl_t  (w_ctrl_t),
        .o_busy    (w_busy),
        .o_done    (w_done)
    );

    logic [WIDTH-1:0] r_mag_a;
    logic [PW-1:0]    r_bs;
    logic [PW-1:0]    r_prod;
    logic             r_neg;
    logic             r_data_t;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_res;
    logic [RADIX_BITS-1:0][PW-1:0] w_pp;

    // Magnitudes fit in WIDTH unsigned bits, including the most-negative value.
    assign w_mag_a = (io_bus.signed_mode && io_bus.multiplier[WIDTH-1])
                     ? (~io_bus.multiplier + 1'b1) : io_bus.multiplier;
    assign w_mag_b = (io_bus.signed_mode && io_bus.multiplicand[WIDTH-1])
                     ? (~io_bus.multiplicand + 1'b1) : io_bus.multiplicand;
    assign w_neg   = io_bus.signed_mode &
                     (io_bus.multiplier[WIDTH-1] ^ io_bus.multiplicand[WIDTH-1]);

    // r_bs already carries the counter*RADIX_BITS alignment; r_mag_a's low bits are the digit.
    for (genvar k = 0; k < RADIX_BITS; k++) begin : g_pp
        assign w_pp[k] = r_mag_a[k] ? (r_bs << k) : '0;
    end

    always_comb begin
        w_sum = r_prod;
        for (int k = 0; k < RADIX_BITS; k++) begin
            w_sum = w_sum + w_pp[k];
        end
    end

    assign w_res = (w_stb.finish && r_neg) ? (~w_sum + 1'b1) : w_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mag_a  <= '0;
            r_bs     <= '0;
            r_prod   <= '0;
            r_neg    <= 1'b0;
            r_data_t <= 1'b0;
        end else if (w_stb.load) begin
            r_mag_a  <= w_mag_a;
            r_bs     <= {{WIDTH{1'b0}}, w_mag_b};
            r_prod   <= '0;
            r_neg    <= w_neg;
            r_data_t <= io_bus.multiplier_t | io_bus.multiplicand_t |
                        io_bus.signed_mode_t | io_bus.start_t;
        end else if (w_stb.step) begin
            r_mag_a  <= r_mag_a >> RADIX_BITS;
            r_bs     <= r_bs << RADIX_BITS;
            r_prod   <= w_res;
        end
    end

    assign io_bus.product       = r_prod;
    assign io_bus.product_t     = r_data_t | w_ctrl_t;
    assign io_bus.busy          = w_busy;
    assign io_bus.busy_t        = w_ctrl_t;
    assign io_bus.productDone   = w_done;
    assign io_bus.productDone_t = w_ctrl_t;

endmodule

// File: tb/tb_seq_multiplier_radix_taint.sv
// Bench: three builds (8/R1, 8/R2, 4/R1) driven in lockstep, checked each cycle
// against a latency/arithmetic model plus hand-computed literals.
module tb_seq_multiplier_radix_taint;

    localparam int IT [3] = '{8, 4, 4};
    localparam int WD [3] = '{8, 8, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start_t, sm, sm_t, a_t, b_t;
    logic [7:0] a, b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int lat [3];

    always #5 clk = ~clk;

    seq_multiplier_radix_taint_if #(.WIDTH(8)) if0 ();
    seq_multiplier_radix_taint_if #(.WIDTH(8)) if1 ();
    seq_multiplier_radix_taint_if #(.WIDTH(4)) if2 ();

    assign {if0.start, if0.start_t, if0.signed_mode, if0.signed_mode_t} = {start, start_t, sm, sm_t};
    assign {if1.start, if1.start_t, if1.signed_mode, if1.signed_mode_t} = {start, start_t, sm, sm_t};
    assign {if2.start, if2.start_t, if2.signed_mode, if2.signed_mode_t} = {start, start_t, sm, sm_t};
    assign {if0.multiplier, if0.multiplier_t, if0.multiplicand, if0.multiplicand_t} = {a, a_t, b, b_t};
    assign {if1.multiplier, if1.multiplier_t, if1.multiplicand, if1.multiplicand_t} = {a, a_t, b, b_t};
    assign {if2.multiplier, if2.multiplier_t, if2.multiplicand, if2.multiplicand_t} = {a[3:0], a_t, b[3:0], b_t};

    seq_multiplier_radix_taint #(.WIDTH(8), .RADIX_BITS(1)) u0 (.clk(clk), .rst(rst), .io_bus(if0.slave));
    seq_multiplier_radix_taint #(.WIDTH(8), .RADIX_BITS(2)) u1 (.clk(clk), .rst(rst), .io_bus(if1.slave));
    seq_multiplier_radix_taint #(.WIDTH(4), .RADIX_BITS(1)) u2 (.clk(clk), .rst(rst), .io_bus(if2.slave));

    logic [2:0][15:0] prod;
    logic [2:0]       pt, bsy, bt, dn, dt;
    assign prod = {{8'h00, if2.product}, if1.product, if0.product};
    assign pt   = {if2.product_t, if1.product_t, if0.product_t};
    assign bsy  = {if2.busy, if1.busy, if0.busy};
    assign bt   = {if2.busy_t, if1.busy_t, if0.busy_t};
    assign dn   = {if2.productDone, if1.productDone, if0.productDone};
    assign dt   = {if2.productDone_t, if1.productDone_t, if0.productDone_t};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact product from plain integer arithmetic, truncated to 2*w bits.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                             input logic s, input int w);
        longint xa, ya, p;
        xa = longint'(x) & ((longint'(1) << w) - 1);
        ya = longint'(y) & ((longint'(1) << w) - 1);
        if (s && xa[w-1]) xa = xa - (longint'(1) << w);
        if (s && ya[w-1]) ya = ya - (longint'(1) << w);
        p = xa * ya;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Model: ph = edges since accept (0 = idle); done visible at ph == ITER+1.
    int         ph    [3];
    logic [15:0] eprod [3];
    logic [15:0] pend  [3];
    logic        mct   [3];
    logic        mdt   [3];

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                ph[d]    <= 0;
                eprod[d] <= '0;
                mct[d]   <= 1'b0;
                mdt[d]   <= 1'b0;
            end else if (ph[d] == 0) begin
                mct[d] <= mct[d] | start_t;
                if (start) begin
                    ph[d]   <= 1;
                    pend[d] <= ref_mul(a, b, sm, WD[d]);
                    mdt[d]  <= a_t | b_t | sm_t | start_t;
                end
            end else if (ph[d] == IT[d] + 1) begin
                ph[d] <= 0;
            end else begin
                ph[d] <= ph[d] + 1;
                if (ph[d] == IT[d]) eprod[d] <= pend[d];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("busy%0d", d),   32'(bsy[d]), 32'(ph[d] != 0));
                chk($sformatf("done%0d", d),   32'(dn[d]),  32'(ph[d] == IT[d] + 1));
                chk($sformatf("busy_t%0d", d), 32'(bt[d]),  32'(mct[d]));
                chk($sformatf("done_t%0d", d), 32'(dt[d]),  32'(mct[d]));
                chk($sformatf("prod_t%0d", d), 32'(pt[d]),  32'(mdt[d] | mct[d]));
                if (ph[d] == 0 || ph[d] == IT[d] + 1)
                    chk($sformatf("prod%0d", d), 32'(prod[d]), 32'(eprod[d]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One accepted operation on all three builds; returns with all idle.
    task automatic op(input logic [7:0] x, input logic [7:0] y, input logic s,
                      input logic xt, input logic yt, input logic st);
        tick();
        a = x; b = y; sm = s; a_t = xt; b_t = yt; sm_t = st; start = 1'b1;
        tick();
        start = 1'b0; a_t = 1'b0; b_t = 1'b0; sm_t = 1'b0;
        for (int d = 0; d < 3; d++) lat[d] = -1;
        for (int n = 0; n <= 9; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (dn[d] && lat[d] < 0) lat[d] = n;
        end
        for (int d = 0; d < 3; d++) chk($sformatf("latency%0d", d), 32'(lat[d]), 32'(IT[d]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; start_t = 1'b0; sm = 1'b0; sm_t = 1'b0;
        a = '0; b = '0; a_t = 1'b0; b_t = 1'b0;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_prod", 32'(prod[1]), 32'h0);
        chk("reset_busy", 32'(bsy), 32'h0);
        chk("reset_taint", 32'({pt, bt, dt}), 32'h0);
        rst = 1'b1;

        // Model pins
        chk("ref_s4", 32'(ref_mul(8'h8, 8'h8, 1'b1, 4)), 32'h0040);
        chk("ref_u8", 32'(ref_mul(8'hFF, 8'hFF, 1'b0, 8)), 32'hFE01);

        // T1 / T2
        op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_prod", 32'(prod[0]), 32'hFE01);
        chk("t1_taint", 32'({pt[0], bt[0], dt[0]}), 32'h0);
        op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_minneg", 32'(prod[1]), 32'h4000);
        op(8'hFD, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_neg", 32'(prod[1]), 32'hFFEB);
        op(8'h58, 8'hA8, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_minneg4", 32'(prod[2]), 32'h0040);

        // T3: full 4-bit sweep, random upper nibbles exercise the 8-bit builds
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    op({4'($urandom), 4'(x)}, {4'($urandom), 4'(y)}, 1'(s), 1'b0, 1'b0, 1'b0);

        // T4: data taint reaches product only
        op(8'h3C, 8'hC5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_pt", 32'(pt[1]), 32'h1);
        chk("t4_bt", 32'(bt[1]), 32'h0);
        chk("t4_dt", 32'(dt[1]), 32'h0);
        op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_clean", 32'(pt[1]), 32'h0);

        // Random traffic incl. starts during CALC/DONE and back-to-back accepts
        for (int i = 0; i < 600; i++) begin
            tick();
            start = ($urandom_range(0, 2) == 0);
            a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
            a_t = ($urandom_range(0, 5) == 0); b_t = ($urandom_range(0, 5) == 0);
            sm_t = ($urandom_range(0, 5) == 0);
        end
        start = 1'b0; a_t = 1'b0; b_t = 1'b0; sm_t = 1'b0;
        repeat (12) tick();

        // T6: start ignored in CALC, reset at CALC cycle 3 aborts
        a = 8'hB7; b = 8'h5C; sm = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_prod", 32'(prod[1]), 32'h0);
        chk("t6_busy", 32'(bsy[1]), 32'h0);
        repeat (12) tick();

        // T5: tainted non-start makes control taint sticky
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        op(8'h05, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_prod", 32'(prod[1]), 32'h001E);
        chk("t5_pt", 32'(pt[1]), 32'h1);
        chk("t5_dt", 32'(dt[1]), 32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_taint", 32'({pt[1], bt[1]}), 32'h0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
